// File: rtl/full_adder_if.sv
// Operand, control and result bundle for the full_adder cell.
// master drives operands/controls; slave (the cell) drives results.
interface full_adder_if;
  logic        A;
  logic        B;
  logic        Cin;
  logic        sub;
  logic        serial_en;
  logic        serial_start;
  logic        in_valid;
  logic        Sum;
  logic        Cout;
  logic        sum_q;
  logic        cout_q;
  logic        carry_q;
  logic        out_valid;
  logic [15:0] op_count;

  modport master (
    output A, B, Cin, sub, serial_en, serial_start, in_valid,
    input  Sum, Cout, sum_q, cout_q, carry_q, out_valid, op_count
  );

  modport slave (
    input  A, B, Cin, sub, serial_en, serial_start, in_valid,
    output Sum, Cout, sum_q, cout_q, carry_q, out_valid, op_count
  );
endinterface

// File: rtl/full_adder.sv
// 1-bit full adder with optional B inversion and a registered stage whose carry
// feeds back for LSB-first bit-serial add/subtract. Macro FULL_ADDER_OPCNT_EN enables op_count.
module full_adder (
  input  logic          clk,
  input  logic          rst,
  full_adder_if.slave   bus
);

  localparam int unsigned CNT_W = 16;

  logic w_be;
  logic w_ce;
  logic w_sum;
  logic w_cout;

  logic r_sum_q;
  logic r_cout_q;
  logic r_carry_q;
  logic r_out_valid;

  // Carry-in select: serial start injects Cin^sub (the +1 of two's complement),
  // later serial bits take the stored carry, so no combinational loop exists.
  always_comb begin
    w_be = bus.B ^ bus.sub;
    w_ce = bus.Cin;
    if (bus.serial_en) begin
      if (bus.serial_start) begin
        w_ce = bus.Cin ^ bus.sub;
      end else begin
        w_ce = r_carry_q;
      end
    end
    w_sum  = bus.A ^ w_be ^ w_ce;
    w_cout = (bus.A & w_be) | (bus.A & w_ce) | (w_be & w_ce);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum_q     <= 1'b0;
      r_cout_q    <= 1'b0;
      r_carry_q   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_sum_q   <= w_sum;
        r_cout_q  <= w_cout;
        r_carry_q <= w_cout;
      end
    end
  end

`ifdef FULL_ADDER_OPCNT_EN
  logic [CNT_W-1:0] r_op_count;

  // Saturating count of accepted operations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_count <= '0;
    end else if (bus.in_valid && (r_op_count != {CNT_W{1'b1}})) begin
      r_op_count <= r_op_count + CNT_W'(1);
    end
  end

  assign bus.op_count = r_op_count;
`else
  assign bus.op_count = {CNT_W{1'b0}};
`endif

  assign bus.Sum       = w_sum;
  assign bus.Cout      = w_cout;
  assign bus.sum_q     = r_sum_q;
  assign bus.cout_q    = r_cout_q;
  assign bus.carry_q   = r_carry_q;
  assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_full_adder.sv
// Directed self-checking bench for full_adder: truth table, subtract, serial
// add/subtract, async reset mid-operation and the op_count option.
module tb_full_adder;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  full_adder_if bus ();

  full_adder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic a, input logic b, input logic cin, input logic s,
                       input logic sen, input logic sst, input logic v);
    bus.A            = a;
    bus.B            = b;
    bus.Cin          = cin;
    bus.sub          = s;
    bus.serial_en    = sen;
    bus.serial_start = sst;
    bus.in_valid     = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] tt [8];
    logic [3:0] add_a, add_b, add_s;
    logic [3:0] sub_a, sub_b, sub_s;

    n_checks = 0;
    n_fail   = 0;
    tt = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    add_a = 4'b0101; add_b = 4'b0011; add_s = 4'b1000;
    sub_a = 4'b0110; sub_b = 4'b0011; sub_s = 4'b0011;

    // Reset state
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    check("rst_sum_q",     16'(bus.sum_q),     16'h0);
    check("rst_cout_q",    16'(bus.cout_q),    16'h0);
    check("rst_carry_q",   16'(bus.carry_q),   16'h0);
    check("rst_out_valid", 16'(bus.out_valid), 16'h0);
    check("rst_op_count",  bus.op_count,       16'h0);

    // Registers hold reset values across an edge with in_valid high
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("rst_hold_cout_q",    16'(bus.cout_q),    16'h0);
    check("rst_hold_out_valid", 16'(bus.out_valid), 16'h0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Parallel truth table
    for (int i = 0; i < 8; i++) begin
      bus.A   = i[2];
      bus.B   = i[1];
      bus.Cin = i[0];
      #10;
      check($sformatf("tt_%0d", i), 16'({bus.Cout, bus.Sum}), 16'(tt[i]));
    end

    // Single-bit subtract
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("sub_100", 16'({bus.Cout, bus.Sum}), 16'b10);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("sub_011", 16'({bus.Cout, bus.Sum}), 16'b01);

    // serial_start ignored in parallel mode: Ce stays Cin=0, Be=1
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    check("start_ignored", 16'({bus.Cout, bus.Sum}), 16'b01);

    // Serial add 0101 + 0011 = 1000
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(add_a[k], add_b[k], 1'b0, 1'b0, 1'b1, (k == 0), 1'b1);
      tick();
      check($sformatf("sadd_sum_q_%0d", k), 16'(bus.sum_q), 16'(add_s[k]));
      check($sformatf("sadd_valid_%0d", k), 16'(bus.out_valid), 16'h1);
    end
    check("sadd_cout_q", 16'(bus.cout_q), 16'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check("sadd_valid_drop", 16'(bus.out_valid), 16'h0);

    // Serial subtract 0110 - 0011 = 0011, no borrow
    for (int k = 0; k < 4; k++) begin
      drive(sub_a[k], sub_b[k], 1'b0, 1'b1, 1'b1, (k == 0), 1'b1);
      tick();
      check($sformatf("ssub_sum_q_%0d", k), 16'(bus.sum_q), 16'(sub_s[k]));
    end
    check("ssub_cout_q",  16'(bus.cout_q),  16'h1);
    check("ssub_carry_q", 16'(bus.carry_q), 16'h1);

    // Async reset between edges discards the carry
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_carry_q",   16'(bus.carry_q),   16'h0);
    check("arst_sum_q",     16'(bus.sum_q),     16'h0);
    check("arst_cout_q",    16'(bus.cout_q),    16'h0);
    check("arst_out_valid", 16'(bus.out_valid), 16'h0);
    #1;
    rst = 1'b0;

    // Next non-start serial bit must see Ce=0 (not Cin=1)
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    #1;
    check("post_rst_comb", 16'({bus.Cout, bus.Sum}), 16'b01);
    tick();
    check("post_rst_sum_q",  16'(bus.sum_q),  16'h1);
    check("post_rst_cout_q", 16'(bus.cout_q), 16'h0);

    // op_count
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    check("opcnt_rst", bus.op_count, 16'h0);
    tick();
    bus.in_valid = 1'b1;
    repeat (5) tick();
    bus.in_valid = 1'b0;
    tick();
`ifdef FULL_ADDER_OPCNT_EN
    check("opcnt_5", bus.op_count, 16'd5);
    bus.in_valid = 1'b1;
    repeat (70000) tick();
    bus.in_valid = 1'b0;
    tick();
    check("opcnt_sat", bus.op_count, 16'hFFFF);
`else
    check("opcnt_off", bus.op_count, 16'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
